// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped refill icache.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    RESP
  } state_e;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_LINES  = 8;
  localparam int DEF_CNT_W      = 32;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(
    input int addr_w,
    input int line_words,
    input int num_lines
  );
    return addr_w - 2 - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_tag_store.sv
// Valid/tag/data arrays: one write port, one async read port, flush-all.
module icache_tag_store #(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25,
  parameter int LINE_W    = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_data_o
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  // A write in the same cycle as a flush leaves that one line valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (flush_i) valid_q <= '0;
      if (we_i) valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_dm_refill.sv
// Direct-mapped read-only icache with handshaked refill, flush and stats.
module icache_dm_refill
  import icache_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpu_req_valid,
  output logic                         cpu_req_ready,
  input  logic [ADDR_W-1:0]            cpu_addr,
  output logic                         cpu_rvalid,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_W-1:0]            mem_req_addr,
  input  logic                         mem_resp_valid,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_resp_data,
  input  logic                         flush,
  output logic                         busy,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [CNT_W-1:0]             miss_cnt
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
  localparam int LINE_W = LINE_WORDS * DATA_W;

  state_e            state_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [OFF_W-1:0]  off_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mreq_q;
  logic [ADDR_W-1:0] maddr_q;
  logic              pend_q;
  logic [CNT_W-1:0]  hit_q;
  logic [CNT_W-1:0]  miss_q;

  logic              st_valid;
  logic [TAG_W-1:0]  st_tag;
  logic [LINE_W-1:0] st_line;
  logic              hit;
  logic              accept;
  logic              to_idle;
  logic              we;
  logic              clr;
  logic [DATA_W-1:0] word;

  assign cpu_req_ready = (state_q == IDLE) && !flush && !pend_q;
  assign accept  = cpu_req_valid && cpu_req_ready;
  assign hit     = st_valid && (st_tag == tag_q);
  assign to_idle = ((state_q == LOOKUP) && hit) || (state_q == RESP);
  assign we      = (state_q == MISS_WAIT) && mem_resp_valid;

  // Deferred flushes land on the edge back into IDLE and again while
  // the pending flag drains, so no stale line survives either way.
  assign clr = ((state_q == IDLE) || to_idle) && (flush || pend_q);

  icache_tag_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W),
    .LINE_W    (LINE_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (clr),
    .we_i       (we),
    .wr_idx_i   (idx_q),
    .wr_tag_i   (tag_q),
    .wr_data_i  (mem_resp_data),
    .rd_idx_i   (idx_q),
    .rd_valid_o (st_valid),
    .rd_tag_o   (st_tag),
    .rd_data_o  (st_line)
  );

  always_comb begin
    word = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      if (off_q == w[OFF_W-1:0]) word = st_line[w*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      idx_q    <= '0;
      off_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      mreq_q   <= 1'b0;
      maddr_q  <= '0;
      pend_q   <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (state_q == IDLE) pend_q <= 1'b0;
      else                 pend_q <= pend_q | flush;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            tag_q   <= cpu_addr[ADDR_W-1 -: TAG_W];
            idx_q   <= cpu_addr[2+OFF_W +: IDX_W];
            off_q   <= cpu_addr[2 +: OFF_W];
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            rvalid_q <= 1'b1;
            rdata_q  <= word;
            if (~&hit_q) hit_q <= hit_q + CNT_W'(1);
            state_q  <= IDLE;
          end else begin
            if (~&miss_q) miss_q <= miss_q + CNT_W'(1);
            mreq_q   <= 1'b1;
            maddr_q  <= {tag_q, idx_q, {(OFF_W+2){1'b0}}};
            state_q  <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) begin
            mreq_q  <= 1'b0;
            state_q <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (mem_resp_valid) state_q <= RESP;
        end
        RESP: begin
          rvalid_q <= 1'b1;
          rdata_q  <= word;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rvalid    = rvalid_q;
  assign cpu_rdata     = rdata_q;
  assign mem_req_valid = mreq_q;
  assign mem_req_addr  = maddr_q;
  assign busy          = (state_q != IDLE) || pend_q;
  assign hit_cnt       = hit_q;
  assign miss_cnt      = miss_q;

endmodule

// File: tb/tb_icache_dm_refill.sv
// Scoreboard bench for icache_dm_refill with a behavioural cache model.
module tb_icache_dm_refill;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req_valid = 1'b0;
  logic         cpu_req_ready;
  logic [31:0]  cpu_addr = '0;
  logic         cpu_rvalid;
  logic [31:0]  cpu_rdata;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic         flush = 1'b0;
  logic         busy;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  icache_dm_refill dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_addr       (cpu_addr),
    .cpu_rvalid     (cpu_rvalid),
    .cpu_rdata      (cpu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .flush          (flush),
    .busy           (busy),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mq[$];
  logic [31:0] mem [logic [31:0]];
  bit          mv [8];
  logic [24:0] mt [8];
  int          hcnt = 0;
  int          mcnt = 0;
  bit          resp_en = 1'b1;
  int          force_delay = -1;
  bit          flush_in_wait = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm, input logic [63:0] act);
    nvec++;
    nerr++;
    $display("FAIL %s: got %0h expected none @%0t", nm, act, $time);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (!mem.exists(k)) mem[k] = $urandom;
    return mem[k];
  endfunction

  function automatic bit is_hit(input logic [31:0] a);
    return mv[a[6:4]] && (mt[a[6:4]] == a[31:7]);
  endfunction

  task automatic model_clear();
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && cpu_rvalid) begin
      if (exp_q.size() == 0) fail("unexp_rvalid", {32'h0, cpu_rdata});
      else chk("rdata", {32'h0, cpu_rdata}, {32'h0, exp_q.pop_front()});
    end
  end

  initial begin : responder
    logic [31:0]  a0;
    logic [127:0] ln;
    int           d;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (resp_en && rst_n && mem_req_valid) begin
        a0 = mem_req_addr;
        if (mq.size() == 0) fail("unexp_mem_req", {32'h0, a0});
        else chk("mem_addr", {32'h0, a0}, {32'h0, mq.pop_front()});
        d = (force_delay >= 0) ? force_delay : $urandom_range(0, 3);
        repeat (d) begin
          @(negedge clk);
          chk("mreq_hold", {31'h0, mem_req_valid, mem_req_addr}, {31'h0, 1'b1, a0});
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        if (flush_in_wait) begin
          flush = 1'b1;
          @(negedge clk);
          flush = 1'b0;
          flush_in_wait = 1'b0;
        end else begin
          d = $urandom_range(1, 3);
          repeat (d) @(negedge clk);
        end
        for (int w = 0; w < 4; w++) ln[w*32 +: 32] = mem_rd(a0 + 32'(4*w));
        mem_resp_valid = 1'b1;
        mem_resp_data  = ln;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input bit midfl, input bit waitfl);
    int n;
    bit got;
    bit h;
    h = is_hit(a);
    cpu_addr = a;
    cpu_req_valid = 1'b1;
    #1;
    n = 0;
    while (!cpu_req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cpu_req_ready) begin
      fail("req_ready_timeout", {32'h0, a});
      cpu_req_valid = 1'b0;
      return;
    end
    exp_q.push_back(mem_rd(a));
    if (h) hcnt++;
    else begin
      mcnt++;
      mq.push_back({a[31:4], 4'h0});
      mv[a[6:4]] = 1'b1;
      mt[a[6:4]] = a[31:7];
    end
    if (midfl || waitfl) model_clear();
    flush_in_wait = waitfl;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) cpu_req_valid = 1'b0;
      if (midfl) flush = (n == 1);
      got = cpu_rvalid;
    end
    if (midfl) flush = 1'b0;
    if (!got) fail("rvalid_timeout", {32'h0, a});
    else begin
      if (h) chk("hit_latency", 64'(n), 64'd2);
      chk("hit_cnt", {32'h0, hit_cnt}, 64'(hcnt));
      chk("miss_cnt", {32'h0, miss_cnt}, 64'(mcnt));
    end
  endtask

  task automatic idle_flush(input logic [31:0] a);
    cpu_addr = a;
    cpu_req_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_blocks_ready", {63'h0, cpu_req_ready}, 64'h0);
    @(negedge clk);
    flush = 1'b0;
    cpu_req_valid = 1'b0;
    model_clear();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    int r;
    logic [31:0] a;
    mem[32'h40] = 32'hA0;
    mem[32'h44] = 32'hB1;
    mem[32'h48] = 32'hC2;
    mem[32'h4C] = 32'hD3;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_ready", {63'h0, cpu_req_ready}, 64'h1);
    chk("rst_rvalid", {63'h0, cpu_rvalid}, 64'h0);
    chk("rst_mreq", {63'h0, mem_req_valid}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_hit", {32'h0, hit_cnt}, 64'h0);
    chk("rst_miss", {32'h0, miss_cnt}, 64'h0);
    @(negedge clk);

    do_req(32'h40, 1'b0, 1'b0);
    do_req(32'h48, 1'b0, 1'b0);
    force_delay = 5;
    do_req(32'hC0, 1'b0, 1'b0);
    force_delay = -1;
    do_req(32'h40, 1'b0, 1'b0);

    idle_flush(32'h48);
    repeat (3) @(negedge clk);
    do_req(32'h48, 1'b0, 1'b0);

    do_req(32'hC4, 1'b0, 1'b1);
    chk("busy_flush_pending", {63'h0, busy}, 64'h1);
    @(negedge clk);
    chk("busy_flush_done", {63'h0, busy}, 64'h0);
    do_req(32'hC4, 1'b0, 1'b0);

    resp_en = 1'b0;
    cpu_addr = 32'h200;
    cpu_req_valid = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 0;
    while (!mem_req_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mreq_before_rst", {63'h0, mem_req_valid}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mreq", {63'h0, mem_req_valid}, 64'h0);
    chk("rst_mid_hit", {32'h0, hit_cnt}, 64'h0);
    chk("rst_mid_miss", {32'h0, miss_cnt}, 64'h0);
    exp_q.delete();
    mq.delete();
    model_clear();
    hcnt = 0;
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    mem_resp_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_no_rvalid", {63'h0, cpu_rvalid}, 64'h0);
    end
    resp_en = 1'b1;
    do_req(32'h200, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      a = 32'($urandom_range(0, 32'h1FF));
      if (r < 5) begin
        idle_flush(a);
        @(negedge clk);
      end else if (r < 12) begin
        do_req(a, 1'b1, 1'b0);
      end else if (r < 17 && !is_hit(a)) begin
        do_req(a, 1'b0, 1'b1);
      end else begin
        do_req(a, 1'b0, 1'b0);
      end
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size() + mq.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
